// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions: default constants, FCS inserter state type and
// the reflected byte-update function also used by the accelerator engine.
package crc32_pkg;

   localparam logic [31:0] DEF_POLY   = 32'hEDB8_8320;
   localparam logic [31:0] DEF_INIT   = 32'hFFFF_FFFF;
   localparam logic [31:0] DEF_XOROUT = 32'hFFFF_FFFF;

   typedef enum logic {
      ST_DATA = 1'b0,
      ST_FCS  = 1'b1
   } state_t;

   // Reflected CRC update of one byte, LSB of the byte first.
   function automatic logic [31:0] crc32_byte_step(
      input logic [31:0] c,
      input logic [7:0]  d,
      input logic [31:0] poly
   );
      logic [31:0] t;
      t = c ^ {24'b0, d};
      for (int i = 0; i < 8; i++) begin
         t = t[0] ? ((t >> 1) ^ poly) : (t >> 1);
      end
      return t;
   endfunction

endpackage

// File: rtl/crc32_byte_step_comb.sv
// Combinational wrapper around the package byte-update function. Kept as its
// own module so it can be equivalence-checked against the accelerator engine.
module crc32_byte_step_comb
   import crc32_pkg::*;
#(
   parameter logic [31:0] POLY = DEF_POLY
) (
   input  logic [31:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [31:0] crc_next
);

   // One byte of CRC update.
   always_comb begin
      crc_next = crc32_byte_step(crc_in, data_in, POLY);
   end

endmodule

// File: rtl/crc32_fcs_inserter.sv
// Byte-stream frame stage: forwards payload through a one-entry output
// register and appends the 4-byte FCS (LSB first) after the last payload byte.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_DATA | payload pass-through, CRC accumulates accepted bytes
// ST_FCS  | input blocked, emitting FCS bytes idx 0..3, then reseed
module crc32_fcs_inserter
   import crc32_pkg::*;
#(
   parameter logic [31:0] POLY   = DEF_POLY,
   parameter logic [31:0] INIT   = DEF_INIT,
   parameter logic [31:0] XOROUT = DEF_XOROUT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic [7:0]  m_data,
   output logic        m_valid,
   output logic        m_last,
   input  logic        m_ready,
   output logic [31:0] crc_out,
   output logic        crc_done
);

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  idx;
   logic [31:0] crc;
   logic [31:0] crc_next;
   logic [31:0] fcs;
   logic [7:0]  fcs_byte;
   logic        slot_free;
   logic        handshake;
   logic        fcs_load;
   logic        fcs_final;

   crc32_byte_step_comb #(
      .POLY (POLY)
   ) u_step (
      .crc_in   (crc),
      .data_in  (s_data),
      .crc_next (crc_next)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_DATA;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: leave DATA on the last payload byte, return after
   // the fourth FCS byte is loaded.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_DATA: if (handshake && s_last) state_nxt = ST_FCS;
         ST_FCS:  if (fcs_final)           state_nxt = ST_DATA;
         default:                          state_nxt = ST_DATA;
      endcase
   end

   // Handshake and FCS selection. s_ready is held low while rst_n is asserted
   // even though the output slot is empty then.
   always_comb begin
      slot_free = !m_valid || m_ready;
      s_ready   = rst_n && (state == ST_DATA) && slot_free;
      handshake = s_valid && s_ready;
      fcs_load  = (state == ST_FCS) && slot_free;
      fcs_final = fcs_load && (idx == 2'd3);
      fcs       = crc ^ XOROUT;
      fcs_byte  = fcs[{idx, 3'b000} +: 8];
   end

   // Output register, CRC accumulator and FCS byte index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data   <= 8'h00;
         m_valid  <= 1'b0;
         m_last   <= 1'b0;
         crc      <= INIT;
         idx      <= 2'd0;
         crc_out  <= 32'h0;
         crc_done <= 1'b0;
      end else begin
         crc_done <= 1'b0;
         if (state == ST_DATA) begin
            if (handshake) begin
               m_data  <= s_data;
               m_valid <= 1'b1;
               m_last  <= 1'b0;
               crc     <= crc_next;
               if (s_last) idx <= 2'd0;
            end else if (slot_free) begin
               m_valid <= 1'b0;
            end
         end else if (fcs_load) begin
            m_data  <= fcs_byte;
            m_valid <= 1'b1;
            m_last  <= (idx == 2'd3);
            idx     <= idx + 2'd1;
            if (idx == 2'd3) begin
               crc_out  <= fcs;
               crc_done <= 1'b1;
               crc      <= INIT;
            end
         end
      end
   end

endmodule

// File: tb/tb_crc32_fcs_inserter.sv
// Bench for the FCS inserter: directed frames with known check values plus
// random frames, compared against a bit-serial CRC model.
module tb_crc32_fcs_inserter;

   localparam logic [31:0] POLY   = 32'hEDB8_8320;
   localparam logic [31:0] INIT   = 32'hFFFF_FFFF;
   localparam logic [31:0] XOROUT = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic        s_ready;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_last;
   logic        m_ready = 1'b1;
   logic [31:0] crc_out;
   logic        crc_done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit bp_en = 1'b0;

   logic [8:0]  out_q[$];
   int          out_cyc[$];
   int          acc_cyc[$];
   int          done_cnt = 0;

   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   logic        prev_last = 1'b0;
   logic        prev_done = 1'b0;

   crc32_fcs_inserter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_last   (m_last),
      .m_ready  (m_ready),
      .crc_out  (crc_out),
      .crc_done (crc_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Output capture, hold-while-stalled and crc_done pulse checks.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
         prev_done  = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
         end
         if (crc_done) begin
            done_cnt++;
            chk("done_with_last", {prev_done, m_valid, m_last}, 3'b011);
         end
         if (m_valid && m_ready) begin
            out_q.push_back({m_last, m_data});
            out_cyc.push_back(cyc);
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         prev_done  = crc_done;
      end
   end

   // Bit-serial reference: one input bit at a time, LSB first.
   function automatic logic [31:0] ref_fcs(input logic [7:0] d[$]);
      logic [31:0] c;
      logic        fb;
      c = INIT;
      foreach (d[i]) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ d[i][b];
            c  = c >> 1;
            if (fb) c = c ^ POLY;
         end
      end
      return c ^ XOROUT;
   endfunction

   function automatic void add_expected(input logic [7:0] d[$], inout logic [8:0] q[$]);
      logic [31:0] f;
      f = ref_fcs(d);
      foreach (d[i]) q.push_back({1'b0, d[i]});
      for (int k = 0; k < 4; k++) q.push_back({(k == 3), f[8*k +: 8]});
   endfunction

   task automatic send_frame(input logic [7:0] d[$], input int gap);
      int t;
      for (int i = 0; i < d.size(); i++) begin
         for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
         end
         s_valid = 1'b1;
         s_data  = d[i];
         s_last  = (i == d.size() - 1);
         t = 0;
         forever begin
            @(negedge clk);
            if (s_ready) break;
            t++;
            if (t > 200) break;
            @(posedge clk); #1;
         end
         chk("accept_timeout", 32'(t <= 200), 32'd1);
         acc_cyc.push_back(cyc);
         @(posedge clk); #1;
         s_valid = 1'b0;
         s_last  = 1'b0;
      end
   endtask

   task automatic wait_out(input int n);
      int t;
      t = 0;
      while (out_q.size() < n && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      repeat (6) @(posedge clk);
      #1;
      chk("out_count", out_q.size(), n);
   endtask

   task automatic check_stream(input string tag, input logic [8:0] exp[$]);
      for (int i = 0; i < exp.size() && i < out_q.size(); i++) begin
         chk($sformatf("%s_byte%0d", tag, i), 32'(out_q[i]), 32'(exp[i]));
      end
   endtask

   task automatic clear_logs();
      out_q.delete();
      out_cyc.delete();
      acc_cyc.delete();
      done_cnt = 0;
   endtask

   initial begin
      logic [7:0] f123[$];
      logic [7:0] fz[$];
      logic [7:0] fr[$];
      logic [8:0] exp[$];
      int         consec;

      f123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      fz   = '{8'h00};

      // Reset values.
      #12;
      chk("rst_outputs", {m_valid, m_last, s_ready, crc_done}, 4'b0000);
      chk("rst_m_data", m_data, 8'h00);
      chk("rst_crc_out", crc_out, 32'h0);
      chk("model_check_value", ref_fcs(f123), 32'hCBF4_3926);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // "123456789" at full rate.
      clear_logs();
      exp.delete();
      add_expected(f123, exp);
      send_frame(f123, 0);
      wait_out(13);
      check_stream("f123", exp);
      chk("f123_fcs_bytes", {out_q[9][7:0], out_q[10][7:0], out_q[11][7:0], out_q[12][7:0]}, 32'h2639F4CB);
      chk("f123_crc_out", crc_out, 32'hCBF4_3926);
      chk("f123_done_cnt", done_cnt, 1);
      chk("f123_latency", out_cyc[0], acc_cyc[0] + 1);
      chk("f123_no_bubble", out_cyc[12] - out_cyc[0], 12);

      // Single zero byte.
      clear_logs();
      exp.delete();
      add_expected(fz, exp);
      send_frame(fz, 0);
      wait_out(5);
      check_stream("fz", exp);
      chk("fz_crc_out", crc_out, 32'hD202_EF8D);
      chk("fz_done_cnt", done_cnt, 1);

      // Two back-to-back frames with s_valid held high.
      clear_logs();
      exp.delete();
      add_expected(f123, exp);
      add_expected(f123, exp);
      send_frame(f123, 0);
      send_frame(f123, 0);
      wait_out(26);
      check_stream("b2b", exp);
      chk("b2b_crc_out", crc_out, 32'hCBF4_3926);
      chk("b2b_done_cnt", done_cnt, 2);
      consec = 1;
      for (int i = 1; i < out_cyc.size(); i++) if (out_cyc[i] != out_cyc[i-1] + 1) consec = 0;
      chk("b2b_no_bubble", consec, 1);
      chk("b2b_second_accept", acc_cyc[9], acc_cyc[8] + 5);

      // Random backpressure.
      clear_logs();
      exp.delete();
      add_expected(f123, exp);
      bp_en = 1'b1;
      send_frame(f123, 0);
      wait_out(13);
      bp_en = 1'b0;
      @(posedge clk); #1;
      check_stream("bp", exp);
      chk("bp_crc_out", crc_out, 32'hCBF4_3926);
      chk("bp_done_cnt", done_cnt, 1);

      // Reset after 4 payload bytes, then a full frame.
      fr = '{8'h31, 8'h32, 8'h33, 8'h34};
      foreach (fr[i]) begin
         s_valid = 1'b1;
         s_data  = fr[i];
         s_last  = 1'b0;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outputs", {m_valid, m_last, s_ready, crc_done}, 4'b0000);
      chk("mid_rst_m_data", m_data, 8'h00);
      chk("mid_rst_crc_out", crc_out, 32'h0);
      clear_logs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp.delete();
      add_expected(f123, exp);
      send_frame(f123, 0);
      chk("rst_crc_out_pending", crc_out, 32'h0);
      wait_out(13);
      check_stream("rst", exp);
      chk("rst_crc_out_final", crc_out, 32'hCBF4_3926);

      // s_valid gaps every other cycle.
      clear_logs();
      exp.delete();
      add_expected(f123, exp);
      send_frame(f123, 1);
      wait_out(13);
      check_stream("gap", exp);
      chk("gap_crc_out", crc_out, 32'hCBF4_3926);
      consec = 1;
      for (int i = 1; i < 9; i++) if (out_cyc[i] != out_cyc[i-1] + 2) consec = 0;
      chk("gap_spacing", consec, 1);

      // Random frames, random gaps and backpressure.
      for (int f = 0; f < 6; f++) begin
         clear_logs();
         exp.delete();
         fr.delete();
         for (int i = 0; i < int'($urandom_range(1, 20)); i++) fr.push_back(8'($urandom));
         add_expected(fr, exp);
         bp_en = 1'b1;
         send_frame(fr, int'($urandom_range(0, 2)));
         wait_out(fr.size() + 4);
         bp_en = 1'b0;
         @(posedge clk); #1;
         check_stream($sformatf("rnd%0d", f), exp);
         chk($sformatf("rnd%0d_crc_out", f), crc_out, ref_fcs(fr));
         chk($sformatf("rnd%0d_done_cnt", f), done_cnt, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
